// File: rtl/disp_pkg.sv
`default_nettype none
// =============================================================================
// Module      : disp_pkg
// Description : Shared constants and run-state encoding for the BCD display path.
// Revision    : 1.0 - initial release
// =============================================================================
package disp_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } run_state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// =============================================================================
// Module      : bcd_digit
// Description : One BCD decade, counts up or down with wrap; carry_out flags wrap value.
// Revision    : 1.0 - initial release
// =============================================================================
module bcd_digit
    import disp_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               en,
    input  logic               up,
    output logic [DIGIT_W-1:0] q,
    output logic               carry_out
);

    // Combinational so a whole wrap chain ripples within the same tick.
    assign carry_out = up ? (q == BCD_MAX) : (q == BCD_MIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= BCD_MIN;
        end else if (clr) begin
            q <= BCD_MIN;
        end else if (en) begin
            if (up) begin
                q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            end else begin
                q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_tick_counter.sv
`default_nettype none
// =============================================================================
// Module      : bcd_tick_counter
// Description : Four-digit BCD up/down event counter with prescaled tick and run/stop button.
// Revision    : 1.0 - initial release
// =============================================================================
module bcd_tick_counter
    import disp_pkg::*;
#(
    parameter int TICK_DIV = 50_000
)
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start_stop,
    input  logic                          clear,
    input  logic                          up_down,
    output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    output logic                          running,
    output logic                          rollover
);

    localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic             s1, s2, s_prev;
    logic             btn_edge;
    run_state_t       state, state_nxt;
    logic [PS_W-1:0]  prescaler;
    logic             tick;
    logic [NUM_DIGITS:0]   en_chain;
    logic [NUM_DIGITS-1:0] wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s1     <= start_stop;
            s2     <= s1;
            s_prev <= s2;
        end
    end

    assign btn_edge = s2 & ~s_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_STOPPED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_STOPPED;
        end else if (btn_edge) begin
            state_nxt = (state == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
        end
    end

    assign running = (state == ST_RUNNING);
    assign tick    = running && (prescaler == PS_LAST) && !clear;

    // Prescaler holds while stopped so a pause keeps the partial period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else if (clear) begin
            prescaler <= '0;
        end else if (running) begin
            prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + PS_W'(1);
        end
    end

    assign en_chain[0] = tick;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .reset_n   (reset_n),
            .clr       (clear),
            .en        (en_chain[i]),
            .up        (up_down),
            .q         (digits[i*DIGIT_W +: DIGIT_W]),
            .carry_out (wrap[i])
        );
        assign en_chain[i+1] = en_chain[i] & wrap[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rollover <= 1'b0;
        end else begin
            rollover <= en_chain[NUM_DIGITS] & ~clear;
        end
    end

endmodule
`default_nettype wire
